// File: rtl/ncl_pkg.sv
// Shared types and helpers for the clocked NCL receiver.
// Holds FSM and rail-classification enums plus the one-hot decoder.
package ncl_pkg;

    localparam int unsigned MAX_RAILS = 64;

    typedef enum logic [1:0] {
        WAIT_DATA,
        HOLD,
        WAIT_NULL
    } rx_state_t;

    typedef enum logic [1:0] {
        CL_NULL,
        CL_DATA,
        CL_MULTI
    } rail_class_t;

    // Lowest set bit wins; only meaningful when exactly one rail is high.
    function automatic int unsigned onehot_to_idx(input logic [MAX_RAILS-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_RAILS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ncl_rx_fifo.sv
// Small synchronous FIFO with exact occupancy output.
// Registered storage, no bypass: a push into an empty FIFO is visible next cycle.
module ncl_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     init,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullLevel = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == FullLevel);
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (PtrW + 1)'(1);
                2'b01:   level_q <= level_q - (PtrW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ncl_sync_rx.sv
// Clocked receiver terminating a 1-of-W NCL channel: synchronizes the rails,
// filters them for stability, acknowledges wavefronts and queues decoded tokens.
module ncl_sync_rx
    import ncl_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SYNC   = 2,
    parameter int unsigned STABLE = 2
) (
    input  logic                     clk,
    input  logic                     init,
    input  logic [W-1:0]             rail_i,
    output logic                     ko_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(W)-1:0]     out_idx,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     err_multi,
    output logic [15:0]              tok_cnt
);

    localparam int unsigned IdxW = $clog2(W);
    localparam int unsigned CntW = $clog2(STABLE + 1);
    localparam logic [CntW-1:0] StableCnt = CntW'(STABLE);

    logic [W-1:0]         sync_q [SYNC];
    logic [W-1:0]         s;
    logic [W-1:0]         s_q;
    logic [CntW-1:0]      stab_cnt_q;
    logic [CntW-1:0]      stab_cur;
    logic                 acc;

    logic [MAX_RAILS-1:0] s_ext;
    int unsigned          ones;
    rail_class_t          cls;
    logic [IdxW-1:0]      data_idx;

    rx_state_t            state_q;
    rx_state_t            state_d;
    logic                 ko_q;
    logic [IdxW-1:0]      hold_idx_q;
    logic                 err_q;
    logic [15:0]          tok_q;

    logic                 push;
    logic [IdxW-1:0]      push_idx;
    logic                 hold_load;
    logic                 err_set;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 slot_free;

    // Rail synchronizer chain
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            for (int i = 0; i < int'(SYNC); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rail_i;
            for (int i = 1; i < int'(SYNC); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC-1];

    always_comb begin
        ones  = 0;
        s_ext = '0;
        s_ext[W-1:0] = s;
        for (int i = 0; i < int'(W); i++) begin
            if (s[i]) begin
                ones = ones + 1;
            end
        end
        if (ones == 0) begin
            cls = CL_NULL;
        end else if (ones == 1) begin
            cls = CL_DATA;
        end else begin
            cls = CL_MULTI;
        end
        data_idx = IdxW'(onehot_to_idx(s_ext));
    end

    // stab_cur counts the current cycle, so a fresh pattern scores 1.
    always_comb begin
        if (s != s_q) begin
            stab_cur = CntW'(1);
        end else if (stab_cnt_q >= StableCnt) begin
            stab_cur = StableCnt;
        end else begin
            stab_cur = stab_cnt_q + CntW'(1);
        end
    end

    assign acc = (stab_cur == StableCnt);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            s_q        <= '0;
            stab_cnt_q <= '0;
        end else begin
            s_q        <= s;
            stab_cnt_q <= stab_cur;
        end
    end

    assign pop       = out_valid && out_ready;
    assign slot_free = !fifo_full || pop;

    // FSM state register
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= WAIT_DATA;
            ko_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ko_q    <= (state_d != WAIT_NULL);
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_DATA: begin
                if (acc && cls == CL_DATA) begin
                    state_d = slot_free ? WAIT_NULL : HOLD;
                end
            end
            HOLD: begin
                if (slot_free) begin
                    state_d = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (acc && cls == CL_NULL) begin
                    state_d = WAIT_DATA;
                end
            end
            default: state_d = WAIT_DATA;
        endcase
    end

    // FSM outputs
    always_comb begin
        push      = 1'b0;
        push_idx  = data_idx;
        hold_load = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            WAIT_DATA: begin
                if (acc && cls == CL_DATA) begin
                    push      = slot_free;
                    hold_load = !slot_free;
                end else if (acc && cls == CL_MULTI) begin
                    err_set = 1'b1;
                end
            end
            HOLD: begin
                push_idx = hold_idx_q;
                push     = slot_free;
            end
            WAIT_NULL: begin
                err_set = acc && (cls == CL_MULTI);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            hold_idx_q <= '0;
            err_q      <= 1'b0;
            tok_q      <= '0;
        end else begin
            if (hold_load) begin
                hold_idx_q <= data_idx;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (push) begin
                tok_q <= tok_q + 16'd1;
            end
        end
    end

    ncl_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IdxW)
    ) u_fifo (
        .clk       (clk),
        .init      (init),
        .push      (push),
        .push_data (push_idx),
        .pop       (pop),
        .head      (out_idx),
        .level     (level_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign ko_o      = ko_q;
    assign err_multi = err_q;
    assign tok_cnt   = tok_q;

endmodule
